// File: rtl/ifc_arb_pkg.sv
// Shared types and constants for the ifc_x/y/z bundle arbiter.
//   arb_state_e : arbiter FSM states (IDLE, GRANT, GAP)
//   IDLE_*      : pattern driven on the bundle when nobody owns it
//   wrap_inc    : modulo-n increment used for the round-robin pointer
package ifc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

    localparam logic IDLE_X = 1'b0;
    localparam logic IDLE_Y = 1'b1;
    localparam logic IDLE_Z = 1'b0;

    // Next index after idx in a ring of n entries.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/ifc_arbiter_rr_pick.sv
// Combinational round-robin priority encoder.
// Searches req starting at rr_ptr and wrapping modulo N_REQ; the first
// requester found wins.
//   req      : request vector
//   rr_ptr   : highest-priority index this cycle
//   valid_c  : at least one request is pending
//   winner_c : index of the winning requester (0 when valid_c is low)
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             valid_c,
    output logic [IDX_W-1:0] winner_c
);

    // Offset 0 is rr_ptr itself; the first hit locks out later offsets.
    always_comb begin
        valid_c  = 1'b0;
        winner_c = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!valid_c && req[IDX_W'((32'(rr_ptr) + i) % N_REQ)]) begin
                valid_c  = 1'b1;
                winner_c = IDX_W'((32'(rr_ptr) + i) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/ifc_arbiter.sv
// Round-robin arbiter sharing one x/y/z interface bundle among N_REQ
// requesters. A grant lasts until the owner's last beat, its request drops,
// or HOLD_MAX cycles elapse; one GAP cycle separates consecutive owners so
// the bundle never carries two owners' data back to back.
//   clk, rst               : clock, asynchronous active-high reset
//   req, last              : per-requester request level / final beat
//   x_in, y_in, z_in       : per-requester payload bits
//   grant                  : one-hot current owner (zero in IDLE/GAP)
//   ifc_I_x/_y/_z          : arbitrated bundle, one cycle behind the owner
//   busy                   : high in GRANT or GAP
//   owner                  : index of the current or most recent owner
module ifc_arbiter
    import ifc_arb_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned HOLD_MAX = 8,
    parameter int unsigned CNT_W    = $clog2(HOLD_MAX + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           last,
    input  logic [N_REQ-1:0]           x_in,
    input  logic [N_REQ-1:0]           y_in,
    input  logic [N_REQ-1:0]           z_in,
    output logic [N_REQ-1:0]           grant,
    output logic                       ifc_I_x,
    output logic                       ifc_I_y,
    output logic                       ifc_I_z,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   owner
);

    localparam int unsigned      IDX_W   = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    arb_state_e       state;
    arb_state_e       next_state;

    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_cnt_d;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] rr_ptr_d;
    logic [IDX_W-1:0] owner_d;
    logic [N_REQ-1:0] grant_d;
    logic             x_d;
    logic             y_d;
    logic             z_d;
    logic             busy_d;

    logic             pick_valid_c;
    logic [IDX_W-1:0] pick_idx_c;
    logic             release_c;

    // Winner search from the round-robin pointer; consulted in IDLE and GAP.
    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req      (req),
        .rr_ptr   (rr_ptr),
        .valid_c  (pick_valid_c),
        .winner_c (pick_idx_c)
    );

    // Any release cause collapses into one release for the current owner.
    assign release_c = (state == GRANT) &&
                       (last[owner] || !req[owner] || (hold_cnt == CNT_MAX));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pick_valid_c) next_state = GRANT;
            GRANT:   if (release_c)    next_state = GAP;
            GAP:     next_state = pick_valid_c ? GRANT : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Next values for every registered output and the pointer/counter.
    always_comb begin
        grant_d    = '0;
        owner_d    = owner;
        hold_cnt_d = hold_cnt;
        rr_ptr_d   = rr_ptr;
        x_d        = IDLE_X;
        y_d        = IDLE_Y;
        z_d        = IDLE_Z;
        busy_d     = (next_state != IDLE);

        case (state)
            GRANT: begin
                // The releasing beat is still forwarded.
                x_d = x_in[owner];
                y_d = y_in[owner];
                z_d = z_in[owner];
                if (release_c) begin
                    // Old owner drops to lowest priority for the next pick.
                    rr_ptr_d = IDX_W'(wrap_inc(32'(owner), N_REQ));
                end else begin
                    grant_d = grant;
                    if (hold_cnt != CNT_MAX) begin
                        hold_cnt_d = hold_cnt + CNT_ONE;
                    end
                end
            end
            default: begin
                if (next_state == GRANT) begin
                    owner_d    = pick_idx_c;
                    grant_d    = N_REQ'(1) << pick_idx_c;
                    hold_cnt_d = CNT_ONE;
                end
            end
        endcase
    end

    // Output, pointer and hold-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant    <= '0;
            owner    <= '0;
            hold_cnt <= '0;
            rr_ptr   <= '0;
            ifc_I_x  <= IDLE_X;
            ifc_I_y  <= IDLE_Y;
            ifc_I_z  <= IDLE_Z;
            busy     <= 1'b0;
        end else begin
            grant    <= grant_d;
            owner    <= owner_d;
            hold_cnt <= hold_cnt_d;
            rr_ptr   <= rr_ptr_d;
            ifc_I_x  <= x_d;
            ifc_I_y  <= y_d;
            ifc_I_z  <= z_d;
            busy     <= busy_d;
        end
    end

endmodule

// File: tb/tb_ifc_arbiter.sv
// Self-checking bench for ifc_arbiter (N_REQ=4, HOLD_MAX=8): directed
// scenarios against hand-derived values, then random traffic against a
// transaction-level reference model.
module tb_ifc_arbiter;

    localparam int N  = 4;
    localparam int HM = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] last;
    logic [3:0] x_in;
    logic [3:0] y_in;
    logic [3:0] z_in;
    logic [3:0] grant;
    logic       ifc_I_x;
    logic       ifc_I_y;
    logic       ifc_I_z;
    logic       busy;
    logic [1:0] owner;

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the bundle (-1 = nobody), how long, pointer.
    int         m_owner;
    int         m_len;
    int         m_ptr;
    int         m_last;
    bit         m_gap;
    logic [3:0] exp_grant;
    logic       exp_x;
    logic       exp_y;
    logic       exp_z;
    logic       exp_busy;
    logic [1:0] exp_owner;

    ifc_arbiter #(
        .N_REQ    (N),
        .HOLD_MAX (HM)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .last    (last),
        .x_in    (x_in),
        .y_in    (y_in),
        .z_in    (z_in),
        .grant   (grant),
        .ifc_I_x (ifc_I_x),
        .ifc_I_y (ifc_I_y),
        .ifc_I_z (ifc_I_z),
        .busy    (busy),
        .owner   (owner)
    );

    always #5 clk = ~clk;

    function automatic int pick(input logic [3:0] r, input int ptr);
        int k;
        for (int i = 0; i < N; i++) begin
            k = (ptr + i) % N;
            if (r[k[1:0]]) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner   = -1;
        m_len     = 0;
        m_ptr     = 0;
        m_last    = 0;
        m_gap     = 1'b0;
        exp_grant = 4'b0;
        exp_x     = 1'b0;
        exp_y     = 1'b1;
        exp_z     = 1'b0;
        exp_busy  = 1'b0;
        exp_owner = 2'd0;
    endtask

    // One clock edge worth of the arbitration rules.
    task automatic model_step();
        int w;
        if (m_owner >= 0) begin
            exp_x = x_in[m_owner[1:0]];
            exp_y = y_in[m_owner[1:0]];
            exp_z = z_in[m_owner[1:0]];
            m_len++;
            m_gap = 1'b0;
            if (last[m_owner[1:0]] || !req[m_owner[1:0]] || m_len >= HM) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_gap   = 1'b1;
            end
        end else begin
            exp_x = 1'b0;
            exp_y = 1'b1;
            exp_z = 1'b0;
            m_gap = 1'b0;
            w = pick(req, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                m_len   = 0;
                m_last  = w;
            end
        end
        exp_grant = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
        exp_busy  = (m_owner >= 0) || m_gap;
        exp_owner = 2'(m_last);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        last = '0;
        x_in = '0;
        y_in = '0;
        z_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (grant !== 4'b0) begin bad++; $display("FAIL reset_grant got=%b want=0000", grant); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (owner !== 2'd0) begin bad++; $display("FAIL reset_owner got=%0d want=0", owner); end
        total++; if ({ifc_I_x, ifc_I_y, ifc_I_z} !== 3'b010) begin bad++; $display("FAIL reset_ifc got=%b want=010", {ifc_I_x, ifc_I_y, ifc_I_z}); end

        req  = 4'b1000;
        x_in = 4'b1000;
        z_in = 4'b1000;
        repeat (3) tick();
        total++; if (grant !== 4'b1000) begin bad++; $display("FAIL midgrant_grant got=%b want=1000", grant); end
        total++; if ({ifc_I_x, ifc_I_y, ifc_I_z} !== 3'b101) begin bad++; $display("FAIL midgrant_ifc got=%b want=101", {ifc_I_x, ifc_I_y, ifc_I_z}); end

        // Asynchronous reset in the middle of a grant, no clock edge.
        #2 rst = 1'b1;
        model_reset();
        #1;
        total++; if (grant !== 4'b0) begin bad++; $display("FAIL async_grant got=%b want=0000", grant); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL async_busy got=%b want=0", busy); end
        total++; if (owner !== 2'd0) begin bad++; $display("FAIL async_owner got=%0d want=0", owner); end
        total++; if ({ifc_I_x, ifc_I_y, ifc_I_z} !== 3'b010) begin bad++; $display("FAIL async_ifc got=%b want=010", {ifc_I_x, ifc_I_y, ifc_I_z}); end

        #2 rst = 1'b0;
        req  = '0;
        x_in = '0;
        z_in = '0;
        tick();
        tick();
        total++; if ({ifc_I_x, ifc_I_y, ifc_I_z} !== 3'b010) begin bad++; $display("FAIL idle_ifc got=%b want=010", {ifc_I_x, ifc_I_y, ifc_I_z}); end
        total++; if (busy !== 1'b0 || grant !== 4'b0) begin bad++; $display("FAIL idle_busy got=%b/%b want=0/0000", busy, grant); end
    endtask

    task automatic test_single_last();
        logic [3:0] want_g;
        logic [2:0] want_ifc;
        logic       want_busy;
        do_reset();
        req  = 4'b0100;
        x_in = 4'b0100;
        y_in = 4'b0000;
        z_in = 4'b0100;
        for (int c = 1; c <= 5; c++) begin
            tick();
            want_g    = (c <= 3) ? 4'b0100 : 4'b0000;
            want_ifc  = (c >= 2 && c <= 4) ? 3'b101 : 3'b010;
            want_busy = (c <= 4);
            total++; if (grant !== want_g) begin bad++; $display("FAIL single_grant c=%0d got=%b want=%b", c, grant, want_g); end
            total++; if ({ifc_I_x, ifc_I_y, ifc_I_z} !== want_ifc) begin bad++; $display("FAIL single_ifc c=%0d got=%b want=%b", c, {ifc_I_x, ifc_I_y, ifc_I_z}, want_ifc); end
            total++; if (busy !== want_busy) begin bad++; $display("FAIL single_busy c=%0d got=%b want=%b", c, busy, want_busy); end
            if (c == 1) begin
                total++; if (owner !== 2'd2) begin bad++; $display("FAIL single_owner got=%0d want=2", owner); end
            end
            if (c == 3) last = 4'b0100;
            if (c == 4) begin
                last = '0;
                req  = '0;
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] want_g;
        int         w;
        do_reset();
        req  = 4'b1111;
        last = 4'b1111;
        x_in = 4'b1010;
        y_in = 4'b0110;
        z_in = 4'b0011;
        for (int k = 1; k <= 9; k++) begin
            tick();
            w      = ((k - 1) / 2) % N;
            want_g = (k % 2 == 1) ? 4'(1 << w) : 4'b0;
            total++; if (grant !== want_g) begin bad++; $display("FAIL rr_grant k=%0d got=%b want=%b", k, grant, want_g); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL rr_busy k=%0d got=%b want=1", k, busy); end
            if (k % 2 == 1) begin
                total++; if (owner !== 2'(w)) begin bad++; $display("FAIL rr_owner k=%0d got=%0d want=%0d", k, owner, w); end
            end
        end
        req  = '0;
        last = '0;
        repeat (3) tick();
    endtask

    task automatic test_timeout();
        logic [3:0] want_g;
        logic       sent;
        do_reset();
        req  = 4'b0010;
        for (int k = 1; k <= 10; k++) begin
            x_in = 4'($urandom);
            sent = x_in[1];
            tick();
            want_g = (k <= HM || k == HM + 2) ? 4'b0010 : 4'b0000;
            total++; if (grant !== want_g) begin bad++; $display("FAIL timeout_grant k=%0d got=%b want=%b", k, grant, want_g); end
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL timeout_busy k=%0d got=%b want=1", k, busy); end
            if (k >= 2 && k <= HM + 1) begin
                total++; if (ifc_I_x !== sent) begin bad++; $display("FAIL timeout_x k=%0d got=%b want=%b", k, ifc_I_x, sent); end
            end
        end
        req  = '0;
        x_in = '0;
        repeat (3) tick();
    endtask

    task automatic test_simultaneous();
        do_reset();
        req = 4'b1110;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k <= HM) begin
                total++; if (grant !== 4'b0010) begin bad++; $display("FAIL simul_grant k=%0d got=%b want=0010", k, grant); end
            end
            if (k == HM) begin
                last = 4'b0010;
                req  = 4'b1100;
            end
            if (k == HM + 1) begin
                last = '0;
                total++; if (grant !== 4'b0000 || busy !== 1'b1) begin bad++; $display("FAIL simul_gap got=%b/%b want=0000/1", grant, busy); end
            end
            if (k == HM + 2) begin
                total++; if (grant !== 4'b0100) begin bad++; $display("FAIL simul_next got=%b want=0100", grant); end
                total++; if (owner !== 2'd2) begin bad++; $display("FAIL simul_owner got=%0d want=2", owner); end
            end
        end
        req = '0;
        repeat (3) tick();
    endtask

    task automatic test_noise();
        logic [3:0] want_g;
        logic [2:0] want_ifc;
        do_reset();
        req  = 4'b0001;
        x_in = 4'b0001;
        y_in = 4'b0000;
        z_in = 4'b0001;
        for (int k = 1; k <= 10; k++) begin
            last[3] = 1'($urandom);
            x_in[3] = 1'($urandom);
            y_in[3] = 1'($urandom);
            z_in[3] = 1'($urandom);
            tick();
            want_g   = (k == HM + 1) ? 4'b0000 : 4'b0001;
            want_ifc = (k >= 2 && k <= HM + 1) ? 3'b101 : 3'b010;
            total++; if (grant !== want_g) begin bad++; $display("FAIL noise_grant k=%0d got=%b want=%b", k, grant, want_g); end
            total++; if ({ifc_I_x, ifc_I_y, ifc_I_z} !== want_ifc) begin bad++; $display("FAIL noise_ifc k=%0d got=%b want=%b", k, {ifc_I_x, ifc_I_y, ifc_I_z}, want_ifc); end
        end
        req  = '0;
        last = '0;
        repeat (3) tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < N; i++) begin
                req[i]  = ($urandom_range(9) < 7);
                last[i] = ($urandom_range(5) == 0);
            end
            x_in = 4'($urandom);
            y_in = 4'($urandom);
            z_in = 4'($urandom);
            tick();
            total++; if (grant !== exp_grant) begin bad++; $display("FAIL rand_grant n=%0d got=%b want=%b", n, grant, exp_grant); end
            total++; if (busy !== exp_busy) begin bad++; $display("FAIL rand_busy n=%0d got=%b want=%b", n, busy, exp_busy); end
            total++; if (owner !== exp_owner) begin bad++; $display("FAIL rand_owner n=%0d got=%0d want=%0d", n, owner, exp_owner); end
            total++; if ({ifc_I_x, ifc_I_y, ifc_I_z} !== {exp_x, exp_y, exp_z}) begin bad++; $display("FAIL rand_ifc n=%0d got=%b want=%b", n, {ifc_I_x, ifc_I_y, ifc_I_z}, {exp_x, exp_y, exp_z}); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        model_reset();
        test_reset();
        test_single_last();
        test_round_robin();
        test_timeout();
        test_simultaneous();
        test_noise();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
